// File: rtl/apb_timer_pkg.sv
// Shared constants for the APB timer register block: register map, bit
// positions and prescaler select encodings.
package apb_timer_pkg;

  localparam int unsigned TDR_ADDR  = 0;
  localparam int unsigned TCR_ADDR  = 1;
  localparam int unsigned TSR_ADDR  = 2;
  localparam int unsigned TIER_ADDR = 3;

  localparam int unsigned TCR_LOAD_BIT   = 7;
  localparam int unsigned TCR_UPDOWN_BIT = 5;
  localparam int unsigned TCR_EN_BIT     = 4;

  // Bits of TCR that are stored and read back (UPDOWN, EN, CKS).
  localparam logic [7:0] TCR_RW_MASK = 8'h33;

  localparam int unsigned TSR_OVF_BIT = 0;
  localparam int unsigned TSR_UNF_BIT = 1;

  typedef enum logic [1:0] {
    CKS_DIV2  = 2'd0,
    CKS_DIV4  = 2'd1,
    CKS_DIV8  = 2'd2,
    CKS_DIV16 = 2'd3
  } cks_e;

  // Terminal value of the divider for a given CKS: 2^(cks+1) - 1.
  function automatic logic [3:0] cks_limit(input logic [1:0] cks);
    case (cks)
      CKS_DIV2:  return 4'd1;
      CKS_DIV4:  return 4'd3;
      CKS_DIV8:  return 4'd7;
      default:   return 4'd15;
    endcase
  endfunction

endpackage

// File: rtl/apb_timer_regs_prescaler.sv
// Programmable prescaler: emits a one-cycle tick every 2^(cks+1) cycles
// while enabled; a synchronous clear restarts the count from zero.
module timer_prescaler
  import apb_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] cks,
  input  logic       clear,
  output logic       tick
);

  logic [3:0] div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= 4'd0;
      tick    <= 1'b0;
    end else if (clear || !enable) begin
      div_cnt <= 4'd0;
      tick    <= 1'b0;
    end else if (div_cnt == cks_limit(cks)) begin
      div_cnt <= 4'd0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 4'd1;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/apb_timer_regs.sv
// APB register front-end for the 8-bit up/down timer core: reload/control
// registers, load pulse, prescaled count tick, sticky flags and interrupt.
module apb_timer_regs
  import apb_timer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic              over,
  input  logic              under,
  output logic [DATA_W-1:0] data_in,
  output logic              init_cnt,
  output logic              updown,
  output logic              en,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] A_TDR  = ADDR_W'(TDR_ADDR);
  localparam logic [ADDR_W-1:0] A_TCR  = ADDR_W'(TCR_ADDR);
  localparam logic [ADDR_W-1:0] A_TSR  = ADDR_W'(TSR_ADDR);
  localparam logic [ADDR_W-1:0] A_TIER = ADDR_W'(TIER_ADDR);

  logic [7:0] tdr;
  logic [7:0] tcr;
  logic [1:0] tier;
  logic       tsr_ovf;
  logic       tsr_unf;
  logic       over_q, over_d;
  logic       under_q, under_d;

  // Handshake: setup is psel & !penable, access is psel & penable; the slave
  // never stalls, so every access phase completes (pready) in one cycle and a
  // write commits on that same edge. Out-of-map accesses complete with
  // pslverr, change nothing and read as zero.
  logic access;
  logic addr_ok;
  logic wr;
  logic wr_tdr, wr_tcr, wr_tsr, wr_tier;

  assign access  = psel & penable;
  assign addr_ok = (paddr <= A_TIER);
  assign wr      = access & pwrite & addr_ok;
  assign wr_tdr  = wr & (paddr == A_TDR);
  assign wr_tcr  = wr & (paddr == A_TCR);
  assign wr_tsr  = wr & (paddr == A_TSR);
  assign wr_tier = wr & (paddr == A_TIER);

  assign pready  = access;
  assign pslverr = access & ~addr_ok;

  always_comb begin
    prdata = '0;
    if (psel && !pwrite && addr_ok) begin
      case (paddr)
        A_TDR:   prdata = tdr;
        A_TCR:   prdata = tcr;
        A_TSR:   prdata = {6'd0, tsr_unf, tsr_ovf};
        A_TIER:  prdata = {6'd0, tier};
        default: prdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdr      <= 8'd0;
      tcr      <= 8'd0;
      tier     <= 2'd0;
      init_cnt <= 1'b0;
    end else begin
      if (wr_tdr)  tdr  <= pwdata;
      if (wr_tcr)  tcr  <= pwdata & TCR_RW_MASK;
      if (wr_tier) tier <= pwdata[1:0];
      init_cnt <= wr_tcr & pwdata[TCR_LOAD_BIT];
    end
  end

  assign data_in = tdr;
  assign updown  = tcr[TCR_UPDOWN_BIT];

  // The core outputs are registered once, then a second stage is kept for
  // edge detection, so a rise in cycle k lands in the flag at k+2.
  logic ovf_set, unf_set;
  logic ovf_clr, unf_clr;

  assign ovf_set = over_q & ~over_d;
  assign unf_set = under_q & ~under_d;
  assign ovf_clr = wr_tsr & pwdata[TSR_OVF_BIT];
  assign unf_clr = wr_tsr & pwdata[TSR_UNF_BIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      over_q  <= 1'b0;
      over_d  <= 1'b0;
      under_q <= 1'b0;
      under_d <= 1'b0;
      tsr_ovf <= 1'b0;
      tsr_unf <= 1'b0;
      irq     <= 1'b0;
    end else begin
      over_q  <= over;
      over_d  <= over_q;
      under_q <= under;
      under_d <= under_q;
      // A hardware set in the same cycle as a W1C keeps the flag set.
      tsr_ovf <= ovf_set | (tsr_ovf & ~ovf_clr);
      tsr_unf <= unf_set | (tsr_unf & ~unf_clr);
      irq     <= (tsr_ovf & tier[TSR_OVF_BIT]) | (tsr_unf & tier[TSR_UNF_BIT]);
    end
  end

  timer_prescaler u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (tcr[TCR_EN_BIT]),
    .cks    (tcr[1:0]),
    .clear  (wr_tcr),
    .tick   (en)
  );

endmodule
